// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one read per cycle into a one-cycle-latency memory and
// buffers returned words with their PC in a prefetch FIFO that drains to decode.
module ifu_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_en,
    output logic                     ifu_rd_req,
    output logic [ADDR_WIDTH-1:0]    ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0]    ifu_rd_data,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc,
    output logic                     instr_valid,
    output logic [DATA_WIDTH-1:0]    instr_data,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     dbg_state_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Handshake: a head word transfers on a cycle where instr_valid and instr_ready are both high;
    // a redirect in the same cycle wins and the transfer does not happen.
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] pending_pc_q, pending_pc_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [ADDR_WIDTH-1:0] mem_pc   [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    logic [CW:0] occupancy;
    logic        push, pop;

    // The in-flight word holds a credit so its push can never find the FIFO full.
    assign occupancy   = {1'b0, count_q} + {{CW{1'b0}}, pending_q};
    assign ifu_rd_req  = (state_q == RUN) && fetch_en && !redirect_valid && (occupancy < DEPTH_C);
    assign ifu_rd_addr = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr_data  = mem_data[rd_ptr_q];
    assign instr_pc    = mem_pc[rd_ptr_q];
    assign fifo_count  = count_q;
    assign dbg_state_o = state_q;
    assign push        = pending_q && !redirect_valid;
    assign pop         = instr_valid && instr_ready && !redirect_valid;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_d    = 1'b0;
        pending_pc_d = pending_pc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;

        case (state_q)
            IDLE:    if (fetch_en)  state_d = RUN;
            RUN:     if (!fetch_en) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (ifu_rd_req) begin
            pc_d         = pc_q + ADDR_WIDTH'(1);
            pending_d    = 1'b1;
            pending_pc_d = pc_q;
        end

        if (redirect_valid) begin
            pc_d     = redirect_pc;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (!push && pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            pending_q    <= 1'b0;
            pending_pc_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_q    <= pending_d;
            pending_pc_q <= pending_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]   <= pending_pc_q;
            mem_data[wr_ptr_q] <= ifu_rd_data;
        end
    end
endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios, expected (pc,data) pairs queued by the stimulus
// and popped by a monitor on every accepted head word.
module tb_ifu_fetch;
    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_en = 1'b0;
    logic          ifu_rd_req;
    logic [AW-1:0] ifu_rd_addr;
    logic [DW-1:0] ifu_rd_data = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready = 1'b0;
    logic [2:0]    fifo_count;
    logic          dbg_state;

    logic [AW+DW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    ifu_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_data(instr_data), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fifo_count(fifo_count), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model: word at address a is 0xA0 + a, returned one cycle after the request.
    always @(posedge clk) begin
        if (ifu_rd_req) ifu_rd_data <= 32'h0000_00A0 + {16'h0, ifu_rd_addr};
    end

    function automatic logic [AW+DW-1:0] word_of(input logic [AW-1:0] pc);
        return {pc, 32'h0000_00A0 + {16'h0, pc}};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL deliver actual pc=%h data=%h required=none t=%0t", instr_pc, instr_data, $time);
            end else begin
                logic [AW+DW-1:0] want;
                want = exp_q.pop_front();
                if ({instr_pc, instr_data} !== want) begin
                    bad++;
                    $display("FAIL deliver actual=%h required=%h t=%0t", {instr_pc, instr_data}, want, $time);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic req_chk(input string name, input logic req, input logic [AW-1:0] addr);
        chk({name, "_req"}, 48'(ifu_rd_req), 48'(req));
        if (req) chk({name, "_addr"}, 48'(ifu_rd_addr), 48'(addr));
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        fetch_en = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        sample();
        chk("rst_req", 48'(ifu_rd_req), 48'(0));
        chk("rst_addr", 48'(ifu_rd_addr), 48'(16'h0000));
        chk("rst_valid", 48'(instr_valid), 48'(0));
        chk("rst_count", 48'(fifo_count), 48'(0));
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        sample();
        chk({name, "_left"}, 48'(exp_q.size()), 48'(0));
        chk({name, "_count"}, 48'(fifo_count), 48'(0));
    endtask

    initial begin
        // Steady stream, then fetch_en drop after the request to addr 7
        do_reset();
        for (int k = 0; k < 8; k++) exp_q.push_back(word_of(AW'(k)));
        fetch_en = 1'b1;
        instr_ready = 1'b1;
        sample();
        req_chk("idle_first", 1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            step();
            sample();
            req_chk("stream", 1'b1, AW'(k));
            if (k == 2) chk("stream_valid_lat", 48'(instr_valid), 48'(1));
            if (k == 1) chk("stream_no_bypass", 48'(instr_valid), 48'(0));
        end
        step();
        fetch_en = 1'b0;
        sample();
        req_chk("drop_en", 1'b0, '0);
        drain("stream_drain");

        // Re-enable resumes at addr 8
        step();
        fetch_en = 1'b1;
        sample();
        req_chk("reen_idle", 1'b0, '0);
        chk("reen_pc_hold", 48'(ifu_rd_addr), 48'(16'h0008));
        exp_q.push_back(word_of(16'h0008));
        step();
        sample();
        req_chk("reen_first", 1'b1, 16'h0008);
        step();
        fetch_en = 1'b0;
        sample();
        req_chk("reen_stop", 1'b0, '0);
        drain("reen_drain");

        // Backpressure: four requests then stall at full
        do_reset();
        fetch_en = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            sample();
            req_chk("bp_fill", 1'b1, AW'(k));
            step();
        end
        sample();
        req_chk("bp_stall1", 1'b0, '0);
        step();
        sample();
        req_chk("bp_stall2", 1'b0, '0);
        chk("bp_full_count", 48'(fifo_count), 48'(4));
        chk("bp_full_valid", 48'(instr_valid), 48'(1));
        exp_q.push_back(word_of(16'h0000));
        step();
        instr_ready = 1'b1;
        sample();
        req_chk("bp_pop_cycle", 1'b0, '0);
        step();
        instr_ready = 1'b0;
        sample();
        req_chk("bp_credit_req", 1'b1, 16'h0004);
        chk("bp_credit_count", 48'(fifo_count), 48'(3));
        step();
        sample();
        req_chk("bp_refull_req", 1'b0, '0);
        chk("bp_pending_count", 48'(fifo_count), 48'(3));
        step();
        sample();
        chk("bp_refull_count", 48'(fifo_count), 48'(4));

        // Redirect with addr 5 in flight and two entries buffered
        exp_q.push_back(word_of(16'h0001));
        exp_q.push_back(word_of(16'h0002));
        step();
        instr_ready = 1'b1;
        sample();
        req_chk("rd_full", 1'b0, '0);
        step();
        sample();
        req_chk("rd_req5", 1'b1, 16'h0005);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'h1234;
        sample();
        req_chk("rd_strobe", 1'b0, '0);
        chk("rd_pre_count", 48'(fifo_count), 48'(2));
        step();
        redirect_valid = 1'b0;
        sample();
        chk("rd_flush_count", 48'(fifo_count), 48'(0));
        chk("rd_flush_valid", 48'(instr_valid), 48'(0));
        req_chk("rd_target", 1'b1, 16'h1234);
        exp_q.push_back(word_of(16'h1234));
        exp_q.push_back(word_of(16'h1235));
        for (int i = 1; i < 4; i++) begin
            step();
            sample();
            req_chk("rd_stream", 1'b1, 16'h1234 + AW'(i));
        end

        // PC wrap via redirect to 0xFFFF
        step();
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFF;
        sample();
        req_chk("wrap_strobe", 1'b0, '0);
        step();
        redirect_valid = 1'b0;
        exp_q.push_back(word_of(16'hFFFF));
        exp_q.push_back(word_of(16'h0000));
        sample();
        req_chk("wrap_ffff", 1'b1, 16'hFFFF);
        step();
        sample();
        req_chk("wrap_0000", 1'b1, 16'h0000);
        step();
        fetch_en = 1'b0;
        sample();
        req_chk("wrap_stop", 1'b0, '0);
        drain("wrap_drain");

        // Asynchronous reset with three buffered words
        do_reset();
        fetch_en = 1'b1;
        step();
        for (int k = 0; k < 4; k++) step();
        sample();
        chk("ar_pre_count", 48'(fifo_count), 48'(3));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req", 48'(ifu_rd_req), 48'(0));
        chk("ar_valid", 48'(instr_valid), 48'(0));
        chk("ar_count", 48'(fifo_count), 48'(0));
        chk("ar_addr", 48'(ifu_rd_addr), 48'(16'h0000));
        step();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        sample();
        req_chk("ar_idle", 1'b0, '0);
        exp_q.push_back(word_of(16'h0000));
        step();
        sample();
        req_chk("ar_restart", 1'b1, 16'h0000);
        step();
        fetch_en = 1'b0;
        sample();
        req_chk("ar_stop", 1'b0, '0);
        drain("ar_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
